// File: rtl/shift_en_reg_pkg.sv
// shift_en_pkg: operation encodings shared by the shift register, its interface and the bench.
package shift_en_pkg;

    typedef enum logic [2:0] {
        HOLD = 3'b000,
        LOAD = 3'b001,
        SHL  = 3'b010,
        SHR  = 3'b011,
        ROL  = 3'b100,
        ROR  = 3'b101,
        CLR  = 3'b110,
        RSVD = 3'b111
    } mode_e;

    function automatic logic is_shift(mode_e m);
        return m inside {SHL, SHR, ROL, ROR};
    endfunction

endpackage

// File: rtl/shift_en_reg_if.sv
// shift_en_reg_if: control, data and status bundle of the shift register.
interface shift_en_reg_if #(parameter int WIDTH = 8);
    import shift_en_pkg::*;
    localparam int CW = $clog2(WIDTH + 1);
    logic            EN;
    mode_e           MODE;
    logic [WIDTH-1:0] D;
    logic            SIN_R;
    logic            SIN_L;
    logic [WIDTH-1:0] Q;
    logic            SOUT_L;
    logic            SOUT_R;
    logic            ZERO;
    logic [CW-1:0]   CNT;
    logic            DONE;
    modport master (
        output EN, MODE, D, SIN_R, SIN_L,
        input  Q, SOUT_L, SOUT_R, ZERO, CNT, DONE
    );
    modport slave (
        input  EN, MODE, D, SIN_R, SIN_L,
        output Q, SOUT_L, SOUT_R, ZERO, CNT, DONE
    );
endinterface

// File: rtl/shift_en_reg_en_reg.sv
// en_reg: W-bit register with enable and asynchronous active-low clear.
module en_reg #(parameter int W = 8) (
    input  logic         clk,
    input  logic         CLRN,
    input  logic         EN,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q
);
    always_ff @(posedge clk or negedge CLRN)
        if (!CLRN)
            Q <= '0;
        else if (EN)
            Q <= D;
endmodule

// File: rtl/shift_en_reg.sv
// shift_en_reg: enabled load/shift/rotate register with shift counter and serialization-done pulse.
module shift_en_reg
    import shift_en_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic CLRN,
    shift_en_reg_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CMAX = CW'(WIDTH);
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d_next;
    logic [CW-1:0]    cnt;
    logic             done;

    always_comb begin
        d_next = q;
        case (bus.MODE)
            LOAD:    d_next = bus.D;
            SHL:     d_next = {q[WIDTH-2:0], bus.SIN_R};
            SHR:     d_next = {bus.SIN_L, q[WIDTH-1:1]};
            ROL:     d_next = {q[WIDTH-2:0], q[WIDTH-1]};
            ROR:     d_next = {q[0], q[WIDTH-1:1]};
            CLR:     d_next = '0;
            default: d_next = q;
        endcase
    end

    en_reg #(.W(WIDTH)) u_reg (
        .clk  (clk),
        .CLRN (CLRN),
        .EN   (bus.EN),
        .D    (d_next),
        .Q    (q)
    );

    // DONE fires only on the shift that reaches WIDTH, so it is cleared on every other edge.
    always_ff @(posedge clk or negedge CLRN)
        if (!CLRN) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (bus.EN && (bus.MODE == LOAD || bus.MODE == CLR)) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (bus.EN && is_shift(bus.MODE)) begin
            cnt  <= (cnt == CMAX) ? cnt : cnt + CW'(1);
            done <= (cnt == CMAX - CW'(1));
        end else begin
            done <= 1'b0;
        end

    assign bus.Q      = q;
    assign bus.SOUT_L = q[WIDTH-1];
    assign bus.SOUT_R = q[0];
    assign bus.ZERO   = (q == '0);
    assign bus.CNT    = cnt;
    assign bus.DONE   = done;
endmodule

// File: doc/shift_en_reg.md
SHIFT_EN_REG -- requirements
Module: shift_en_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range WIDTH >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 CLRN  input  1  asynchronous active-low clear (reset) of all state.
REQ-004 EN  input  1  enable; low = every register holds, MODE ignored.
REQ-005 MODE  input  3  operation select, encodings per REQ-011.
REQ-006 D  input  WIDTH  parallel load data.
REQ-007 SIN_R  input  1  serial bit entering Q[0] on shift-left.
REQ-008 SIN_L  input  1  serial bit entering Q[WIDTH-1] on shift-right.
REQ-009 Q  output  WIDTH  register contents; SOUT_L output 1 = Q[WIDTH-1]; SOUT_R output 1 = Q[0]; ZERO output 1 = (Q == 0), all combinational from Q.
REQ-010 CNT  output  $clog2(WIDTH+1)  shift count since last LOAD/CLR; DONE  output  1  one-cycle registered pulse on serialization complete.

Function
REQ-011 MODE decode with EN=1: 000 HOLD; 001 LOAD Q<=D; 010 SHL Q<={Q[W-2:0],SIN_R}; 011 SHR Q<={SIN_L,Q[W-1:1]}; 100 ROL Q<={Q[W-2:0],Q[W-1]}; 101 ROR Q<={Q[0],Q[W-1:1]}; 110 CLR Q<=0 synchronous; 111 HOLD (reserved).
REQ-012 Latency: Q reflects the selected operation one rising edge after sampling; no combinational path D->Q.
REQ-013 "Shift op" = modes 010,011,100,101 with EN=1.
REQ-014 CNT: LOAD or CLR sets CNT<=0; shift op increments CNT, saturating at WIDTH; HOLD/reserved/EN=0 hold CNT.
REQ-015 DONE: registered; high for exactly the one cycle following the edge on which a shift op moves CNT from WIDTH-1 to WIDTH; low otherwise.
REQ-016 Saturation: further shift ops at CNT=WIDTH still shift Q but produce no additional DONE.
REQ-017 LOAD/CLR while CNT=WIDTH or DONE=1: CNT<=0, DONE<=0 on that edge.
REQ-018 EN=0 on the edge where CNT=WIDTH-1: no increment, no DONE; DONE occurs on the next enabled shift op.

Reset
REQ-019 CLRN low asynchronously forces Q=0, CNT=0, DONE=0 without a clock edge, regardless of EN/MODE.
REQ-020 CLRN low mid-serialization discards progress; after CLRN rises first enabled edge behaves as from reset state.
REQ-021 Release of CLRN is not synchronized inside the block; the caller supplies a release synchronous to clk.

Structure
REQ-022 Package shift_en_pkg holds the MODE enum type (HOLD, LOAD, SHL, SHR, ROL, ROR, CLR, RSVD) and encodings; top and bench import it.
REQ-023 One sub-module en_reg (parameter W; ports clk, CLRN, EN, D[W-1:0], Q[W-1:0]; async active-low clear, hold when EN low) instantiated for Q storage; next-state mux, CNT and DONE logic in shift_en_reg.
REQ-024 No latches; one next-state mux for Q; all outputs other than SOUT_L/SOUT_R/ZERO are registered.

Verification (WIDTH=8)
REQ-025 Async reset: Q=8'h3C, CNT=3, pulse CLRN low between edges -> Q=00, CNT=0, DONE=0, ZERO=1 before the next edge.
REQ-026 Enable: EN=1 LOAD D=8'hA5 -> Q=A5 after one edge; then EN=0 MODE=LOAD D=8'hFF for 3 edges -> Q stays A5, CNT stays 0.
REQ-027 Serialize: from A5, SHL with SIN_R=0 for 8 edges -> Q = 4A,94,28,50,A0,40,80,00; SOUT_L sequence before each edge 1,0,1,0,0,1,0,1; CNT=8 and DONE=1 only in the cycle after the 8th edge.
REQ-028 Rotate/saturate: LOAD 8'h81, ROR x9 -> Q=81 after 8 rotates, C0 after 9th; CNT saturates at 8; exactly one DONE pulse.
REQ-029 Simultaneous/boundary: CNT=7, EN=0 one edge then SHR SIN_L=1 -> DONE on the cycle after the SHR edge only; with DONE=1 apply CLR -> Q=00, CNT=0, DONE=0 next cycle; MODE=111 -> Q, CNT unchanged.
